arp_sequencer: RTL and testbench

Step arpeggiator that sits directly upstream of `voice`, driving its `note` and `gate` inputs. It steps through a programmable table of semitone offsets added to a base note, at a rate measured in samples. It supports up, down and (optionally) ping-pong ordering. It runs entirely on the sample clock, so step and gate lengths are exact sample counts.

---
 rtl/arp_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_arp_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/arp_sequencer.sv
// Step arpeggiator: walks a programmable semitone-offset table over a base note, one step per step_len samples.
// Optional feature macro: ARP_PINGPONG_EN enables ping-pong ordering (mode 2'b10) and its direction register.
module arp_sequencer #(
    parameter int  STEPS = 8,
    parameter int  CNTW  = 16,
    localparam int IDXW  = $clog2(STEPS)
) (
    input  logic            sample_clock,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic [6:0]      base_note,
    input  logic [IDXW:0]   length,
    input  logic [CNTW-1:0] step_len,
    input  logic [CNTW-1:0] gate_len,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_addr,
    input  logic [6:0]      wr_data,
    output logic [6:0]      note,
    output logic            gate,
    output logic [IDXW-1:0] step_idx,
    output logic            step_strobe
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [IDXW:0]   LEN_ZERO = {(IDXW+1){1'b0}};
    localparam logic [IDXW:0]   LEN_ONE  = (IDXW+1)'(1'b1);
    localparam logic [IDXW:0]   LEN_MAX  = (IDXW+1)'(STEPS);
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1'b1);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1'b1);

    // base + offset in 8 bits, clipped to the top MIDI note
    function automatic logic [6:0] sat_note(input logic [6:0] base, input logic [6:0] ofs);
        logic [7:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        if (sum[7]) begin
            return 7'd127;
        end else begin
            return sum[6:0];
        end
    endfunction

    logic [6:0]      tbl_r [STEPS];
    state_t          state_r, state_nxt_s;
    logic [IDXW-1:0] idx_r, idx_nxt_s;
    logic [6:0]      note_r, note_nxt_s;
    logic            gate_r, gate_nxt_s;
    logic            strobe_r, strobe_nxt_s;
    logic [CNTW-1:0] cnt_r, cnt_nxt_s;
    logic [CNTW:0]   cnt_inc_s;
    logic [IDXW:0]   leff_s, leff_m1_s, idx_wide_s;
    logic [CNTW-1:0] seff_m1_s;
    logic            load_s;
    logic [IDXW-1:0] load_idx_s, adv_idx_s;
`ifdef ARP_PINGPONG_EN
    logic            dir_r, dir_nxt_s, adv_dir_s;
`endif

    // Effective length / step period after clamping the degenerate settings
    always_comb begin
        if (length == LEN_ZERO) begin
            leff_s = LEN_ONE;
        end else if (length > LEN_MAX) begin
            leff_s = LEN_MAX;
        end else begin
            leff_s = length;
        end
        leff_m1_s  = leff_s - LEN_ONE;
        idx_wide_s = {1'b0, idx_r};
        if (step_len == CNT_ZERO) begin
            seff_m1_s = CNT_ZERO;
        end else begin
            seff_m1_s = step_len - CNT_ONE;
        end
        cnt_inc_s = {1'b0, cnt_r} + {{CNTW{1'b0}}, 1'b1};
    end

    // Index of the step that follows the current one; an index beyond a shrunk length restarts the pattern
    always_comb begin
        adv_idx_s = IDX_ZERO;
`ifdef ARP_PINGPONG_EN
        adv_dir_s = dir_r;
`endif
        case (mode)
            2'b01: begin
                if ((idx_r == IDX_ZERO) || (idx_wide_s >= leff_s)) begin
                    adv_idx_s = leff_m1_s[IDXW-1:0];
                end else begin
                    adv_idx_s = idx_r - IDX_ONE;
                end
            end
`ifdef ARP_PINGPONG_EN
            2'b10: begin
                if ((idx_wide_s >= leff_s) || (leff_s == LEN_ONE)) begin
                    adv_idx_s = IDX_ZERO;
                    adv_dir_s = 1'b0;
                end else if (!dir_r) begin
                    if (idx_wide_s == leff_m1_s) begin
                        adv_idx_s = idx_r - IDX_ONE;
                        adv_dir_s = 1'b1;
                    end else begin
                        adv_idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    if (idx_r == IDX_ZERO) begin
                        adv_idx_s = IDX_ONE;
                        adv_dir_s = 1'b0;
                    end else begin
                        adv_idx_s = idx_r - IDX_ONE;
                    end
                end
            end
`endif
            default: begin
                if (idx_wide_s >= leff_m1_s) begin
                    adv_idx_s = IDX_ZERO;
                end else begin
                    adv_idx_s = idx_r + IDX_ONE;
                end
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        note_nxt_s   = note_r;
        gate_nxt_s   = gate_r;
        strobe_nxt_s = 1'b0;
        cnt_nxt_s    = cnt_r;
        load_s       = 1'b0;
        load_idx_s   = idx_r;
`ifdef ARP_PINGPONG_EN
        dir_nxt_s    = dir_r;
`endif
        case (state_r)
            ST_IDLE: begin
                gate_nxt_s = 1'b0;
                if (enable) begin
                    state_nxt_s = ST_RUN;
                    load_s      = 1'b1;
                    load_idx_s  = (mode == 2'b01) ? leff_m1_s[IDXW-1:0] : IDX_ZERO;
`ifdef ARP_PINGPONG_EN
                    dir_nxt_s   = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                    gate_nxt_s  = 1'b0;
                end else if (cnt_r == seff_m1_s) begin
                    load_s     = 1'b1;
                    load_idx_s = adv_idx_s;
`ifdef ARP_PINGPONG_EN
                    dir_nxt_s  = adv_dir_s;
`endif
                end else begin
                    cnt_nxt_s  = cnt_inc_s[CNTW-1:0];
                    gate_nxt_s = (cnt_inc_s < {1'b0, gate_len});
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // A simultaneous write to this entry lands after this read, so the old offset is used
        if (load_s) begin
            idx_nxt_s    = load_idx_s;
            note_nxt_s   = sat_note(base_note, tbl_r[load_idx_s]);
            strobe_nxt_s = 1'b1;
            cnt_nxt_s    = CNT_ZERO;
            gate_nxt_s   = (gate_len != CNT_ZERO);
        end else begin
            idx_nxt_s = idx_nxt_s;
        end
    end

    // Offset table
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_r[i] <= 7'd0;
            end
        end else if (wr_en) begin
            tbl_r[wr_addr] <= wr_data;
        end
    end

    // State, counter and output registers
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= IDX_ZERO;
            note_r   <= 7'd0;
            gate_r   <= 1'b0;
            strobe_r <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            idx_r    <= idx_nxt_s;
            note_r   <= note_nxt_s;
            gate_r   <= gate_nxt_s;
            strobe_r <= strobe_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

`ifdef ARP_PINGPONG_EN
    // Ping-pong direction (0 = ascending)
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            dir_r <= 1'b0;
        end else begin
            dir_r <= dir_nxt_s;
        end
    end
`endif

    assign note        = note_r;
    assign gate        = gate_r;
    assign step_idx    = idx_r;
    assign step_strobe = strobe_r;

endmodule

// File: tb/tb_arp_sequencer.sv
// Self-checking bench for arp_sequencer: directed and randomized runs against a closed-form sequence model.
module tb_arp_sequencer;
    localparam int STEPS = 8;
    localparam int CNTW  = 16;
    localparam int IDXW  = 3;

    logic            sample_clock = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [6:0]      base_note = 7'd0;
    logic [IDXW:0]   length = 4'd0;
    logic [CNTW-1:0] step_len = 16'd0;
    logic [CNTW-1:0] gate_len = 16'd0;
    logic            wr_en = 1'b0;
    logic [IDXW-1:0] wr_addr = 3'd0;
    logic [6:0]      wr_data = 7'd0;
    logic [6:0]      note;
    logic            gate;
    logic [IDXW-1:0] step_idx;
    logic            step_strobe;

    int n_cmp  = 0;
    int n_fail = 0;
    int tbl [STEPS];
    int pp_en;

    arp_sequencer #(.STEPS(STEPS), .CNTW(CNTW)) dut (
        .sample_clock(sample_clock), .rst(rst), .enable(enable), .mode(mode),
        .base_note(base_note), .length(length), .step_len(step_len), .gate_len(gate_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note(note), .gate(gate), .step_idx(step_idx), .step_strobe(step_strobe)
    );

    always #5 sample_clock = ~sample_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int n, input int g, input int i, input int s);
        check({tag, ".note"}, {25'd0, note}, n);
        check({tag, ".gate"}, {31'd0, gate}, g);
        check({tag, ".idx"}, {29'd0, step_idx}, i);
        check({tag, ".strobe"}, {31'd0, step_strobe}, s);
    endtask

    // Entered just after a falling edge; returns just after the next one
    task automatic write_tbl(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 7'(d);
        @(negedge sample_clock);
        wr_en = 1'b0;
        tbl[a] = d;
    endtask

    // Enable, run n cycles with fixed settings, disable, and check every cycle against the model.
    // wr_t >= 0 writes table[wa]=wd on the edge after cycle wr_t.
    task automatic run_seg(input string tag, input int m, input int len, input int sl, input int gl,
                           input int base, input int n, input int wr_t, input int wa, input int wd);
        int seq[$];
        int leff, seff, s, c, ei, en, pend;
        leff = (len == 0) ? 1 : ((len > STEPS) ? STEPS : len);
        seff = (sl == 0) ? 1 : sl;
        if (m == 1) begin
            for (int k = leff - 1; k >= 0; k--) seq.push_back(k);
        end else if (m == 2 && pp_en == 1) begin
            for (int k = 0; k < leff; k++) seq.push_back(k);
            for (int k = leff - 2; k >= 1; k--) seq.push_back(k);
        end else begin
            for (int k = 0; k < leff; k++) seq.push_back(k);
        end
        mode = 2'(m); length = 4'(len); step_len = 16'(sl); gate_len = 16'(gl);
        base_note = 7'(base); enable = 1'b1;
        pend = 0; en = 0; ei = 0;
        for (int t = 0; t < n; t++) begin
            @(negedge sample_clock);
            s = t / seff;
            c = t % seff;
            ei = seq[s % seq.size()];
            if (c == 0) en = (base + tbl[ei] > 127) ? 127 : base + tbl[ei];
            check_all(tag, en, (c < gl) ? 1 : 0, ei, (c == 0) ? 1 : 0);
            if (pend == 1) begin
                tbl[wa] = wd; wr_en = 1'b0; pend = 0;
            end
            if (t == wr_t) begin
                wr_en = 1'b1; wr_addr = 3'(wa); wr_data = 7'(wd); pend = 1;
            end
        end
        enable = 1'b0;
        @(negedge sample_clock);
        if (pend == 1) begin
            tbl[wa] = wd; wr_en = 1'b0;
        end
        check_all({tag, ".off"}, en, 0, ei, 0);
        @(negedge sample_clock);
        check_all({tag, ".idle"}, en, 0, ei, 0);
    endtask

    initial begin
`ifdef ARP_PINGPONG_EN
        pp_en = 1;
`else
        pp_en = 0;
`endif
        for (int i = 0; i < STEPS; i++) tbl[i] = 0;
        #1;
        check_all("reset", 0, 0, 0, 0);
        @(negedge sample_clock);
        rst = 1'b0;

        write_tbl(0, 0); write_tbl(1, 4); write_tbl(2, 7); write_tbl(3, 12);
        write_tbl(4, 1); write_tbl(5, 2); write_tbl(6, 3); write_tbl(7, 5);
        run_seg("up",       0, 4, 4, 2, 60, 20, -1, 0, 0);
        run_seg("down",     1, 4, 4, 2, 60, 22, -1, 0, 0);
        run_seg("pingpong", 2, 4, 2, 1, 60, 18, -1, 0, 0);
        run_seg("rsvd",     3, 4, 1, 1, 60, 6, -1, 0, 0);
        run_seg("sat",      0, 4, 1, 1, 120, 8, -1, 0, 0);
        run_seg("step0",    0, 4, 0, 3, 60, 10, -1, 0, 0);
        run_seg("len0",     0, 0, 2, 1, 60, 8, -1, 0, 0);
        run_seg("len9",     0, 9, 1, 1, 60, 18, -1, 0, 0);
        run_seg("legato",   0, 4, 4, 10, 60, 16, -1, 0, 0);
        run_seg("gate0",    0, 4, 3, 0, 60, 12, -1, 0, 0);
        run_seg("wrmid",    0, 4, 4, 2, 60, 28, 9, 2, 5);
        run_seg("wrsame",   0, 4, 4, 2, 60, 20, 6, 2, 9);

        // Asynchronous reset between edges while running
        mode = 2'b00; length = 4'd4; step_len = 16'd3; gate_len = 16'd2;
        base_note = 7'd60; enable = 1'b1;
        repeat (5) @(negedge sample_clock);
        @(posedge sample_clock);
        #2 rst = 1'b1;
        #1 check_all("arst", 0, 0, 0, 0);
        @(negedge sample_clock);
        rst = 1'b0; enable = 1'b0;
        for (int i = 0; i < STEPS; i++) tbl[i] = 0;
        #1 check_all("arst.hold", 0, 0, 0, 0);
        run_seg("postrst", 0, 4, 2, 1, 50, 12, -1, 0, 0);

        for (int r = 0; r < 24; r++) begin
            int n, wt;
            if ($urandom_range(0, 2) == 0) write_tbl($urandom_range(0, 7), $urandom_range(0, 127));
            n  = $urandom_range(2, 40);
            wt = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 2) : -1;
            run_seg("rand", $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 6),
                    $urandom_range(0, 7), $urandom_range(0, 127), n, wt,
                    $urandom_range(0, 7), $urandom_range(0, 127));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
